// File: rtl/prio_enc_queue_pkg.sv
// Shared definitions for the priority-encoder request queue: mode encodings
// and the index-width helper used by the interface, picker and top level.
package prio_enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for n request lines, never less than one bit so that a
    // two-source queue still has a usable index.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((32'sd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/prio_enc_queue_if.sv
// Bundle of the request side and the issued-index side of the queue.
// The master modport drives requests and ready; the slave is the queue.
interface prio_enc_queue_if
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2_min1(N)
) ();

    logic         en;
    logic [N-1:0] req;
    logic         mode;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] pending;
    logic         drop;

    modport master (
        output en,
        output req,
        output mode,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  pending,
        input  drop
    );

    modport slave (
        input  en,
        input  req,
        input  mode,
        input  out_ready,
        output out_valid,
        output out_idx,
        output pending,
        output drop
    );

endinterface

// File: rtl/prio_enc_queue_pick.sv
// Combinational picker: finds the winning bit of a request vector.
// In fixed order the highest set index wins. In rotating order the vector
// is rotated right by the start index so that index start-1 lands on the
// top bit, the highest set bit is found, and the result is rotated back.
// All wraps are modulo N, so non-power-of-two N never sees phantom bits.
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = clog2_min1(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    input  logic         rr,
    output logic         any,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    localparam logic [W:0]   N_WIDE   = (W+1)'(N);
    localparam logic [N-1:0] ONE_BIT0 = {{(N-1){1'b0}}, 1'b1};

    logic [W-1:0] w_shift;
    logic [N-1:0] w_rot;
    logic [W-1:0] w_hi;
    logic [W:0]   w_sum;
    logic [W:0]   w_src;

    // Rotation amount: rotating order starts below the last winner, fixed order does not rotate.
    always_comb begin
        w_shift = {W{1'b0}};
        if (rr == MODE_RR) begin
            w_shift = start;
        end else begin
            w_shift = {W{1'b0}};
        end
    end

    // Rotate the request vector right by w_shift, wrapping modulo N.
    always_comb begin
        w_rot = {N{1'b0}};
        w_src = {(W+1){1'b0}};
        for (int i = 0; i < N; i++) begin
            w_src = {1'b0, W'(i)} + {1'b0, w_shift};
            if (w_src >= N_WIDE) begin
                w_src = w_src - N_WIDE;
            end else begin
                w_src = w_src;
            end
            w_rot[i] = vec[w_src[W-1:0]];
        end
    end

    // Highest set bit of the rotated vector; later iterations override earlier ones.
    always_comb begin
        w_hi = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (w_rot[i]) begin
                w_hi = W'(i);
            end else begin
                w_hi = w_hi;
            end
        end
    end

    // Undo the rotation to recover the real source index, again modulo N.
    always_comb begin
        w_sum = {1'b0, w_hi} + {1'b0, w_shift};
        if (w_sum >= N_WIDE) begin
            w_sum = w_sum - N_WIDE;
        end else begin
            w_sum = w_sum;
        end
    end

    // Final outputs: winner index and its one-hot mask (empty when nothing requests).
    always_comb begin
        any = |vec;
        idx = w_sum[W-1:0];
        if (any) begin
            onehot = ONE_BIT0 << w_sum[W-1:0];
        end else begin
            onehot = {N{1'b0}};
        end
    end

endmodule

// File: rtl/prio_enc_queue.sv
// Registered priority-encoder request queue. Request vectors are merged into
// a pending set; one index per accepted transfer is issued on a valid/ready
// output, highest-index-first or rotating after the last rotating winner.
module prio_enc_queue
    import prio_enc_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int RR_EN = 1,
    localparam int W     = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            rst,
    prio_enc_queue_if.slave bus
);

    logic [N-1:0] r_pending;
    logic         r_out_valid;
    logic [W-1:0] r_out_idx;
    logic [W-1:0] r_last;
    logic         r_drop;

    logic         w_rr_mode;
    logic [N-1:0] w_req_cap;
    logic         w_free;
    logic         w_any;
    logic         w_fire;
    logic [W-1:0] w_pick_idx;
    logic [N-1:0] w_pick_onehot;
    logic [N-1:0] w_pick_mask;
    logic [N-1:0] w_pending_nxt;
    logic         w_valid_nxt;
    logic [W-1:0] w_idx_nxt;
    logic [W-1:0] w_last_nxt;
    logic         w_drop_nxt;

    // Without round-robin support the mode input is tied off to fixed order.
    generate
        if (RR_EN != 0) begin : g_rr
            assign w_rr_mode = (bus.mode == MODE_RR);
        end else begin : g_fixed
            assign w_rr_mode = MODE_FIXED;
        end
    endgenerate

    // Mux (not AND) so undefined req bits cannot leak in while capture is disabled.
    always_comb begin
        if (bus.en) begin
            w_req_cap = bus.req;
        end else begin
            w_req_cap = {N{1'b0}};
        end
    end

    prio_pick #(
        .N (N)
    ) u_pick (
        .vec    (r_pending),
        .start  (r_last),
        .rr     (w_rr_mode),
        .any    (w_any),
        .idx    (w_pick_idx),
        .onehot (w_pick_onehot)
    );

    // Next-state for pending set, output slot, rotation pointer and drop flag.
    always_comb begin
        w_free        = ~r_out_valid | bus.out_ready;
        w_fire        = w_free & w_any;
        w_pick_mask   = {N{1'b0}};
        w_valid_nxt   = r_out_valid;
        w_idx_nxt     = r_out_idx;
        w_last_nxt    = r_last;

        if (w_fire) begin
            w_pick_mask = w_pick_onehot;
        end else begin
            w_pick_mask = {N{1'b0}};
        end

        // A free slot either takes the new winner or goes idle keeping the old index.
        if (w_free) begin
            w_valid_nxt = w_any;
            if (w_any) begin
                w_idx_nxt = w_pick_idx;
            end else begin
                w_idx_nxt = r_out_idx;
            end
        end else begin
            w_valid_nxt = r_out_valid;
            w_idx_nxt   = r_out_idx;
        end

        // Only rotating-order picks move the pointer.
        if (w_fire && w_rr_mode) begin
            w_last_nxt = w_pick_idx;
        end else begin
            w_last_nxt = r_last;
        end

        // A request for the bit being issued now is re-captured, not merged.
        w_pending_nxt = (r_pending & ~w_pick_mask) | w_req_cap;
        w_drop_nxt    = |(w_req_cap & r_pending & ~w_pick_mask);
    end

    // State registers; reset overrides every other update, including a stalled transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= {N{1'b0}};
            r_out_valid <= 1'b0;
            r_out_idx   <= {W{1'b0}};
            r_last      <= {W{1'b0}};
            r_drop      <= 1'b0;
        end else begin
            r_pending   <= w_pending_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_idx   <= w_idx_nxt;
            r_last      <= w_last_nxt;
            r_drop      <= w_drop_nxt;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_idx   = r_out_idx;
    assign bus.pending   = r_pending;
    assign bus.drop      = r_drop;

endmodule

// File: tb/tb_prio_enc_queue.sv
// Bench for prio_enc_queue: three instances (N=8, 5, 2) share stimulus and
// are compared every cycle against a set-based reference model, plus
// directed checks with hand-derived constants.
module tb_prio_enc_queue;
    import prio_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic        ready;
    logic [63:0] req;

    int n_checks = 0;
    int n_errors = 0;

    localparam int NI = 3;
    int          nn     [NI] = '{8, 5, 2};
    logic [63:0] m_pend [NI];
    bit          m_valid[NI];
    int          m_idx  [NI];
    int          m_last [NI];
    bit          m_drop [NI];

    always #5 clk = ~clk;

    prio_enc_queue_if #(.N(8)) bus8 ();
    prio_enc_queue_if #(.N(5)) bus5 ();
    prio_enc_queue_if #(.N(2)) bus2 ();

    assign bus8.en = en;  assign bus8.mode = mode;  assign bus8.out_ready = ready;  assign bus8.req = req[7:0];
    assign bus5.en = en;  assign bus5.mode = mode;  assign bus5.out_ready = ready;  assign bus5.req = req[4:0];
    assign bus2.en = en;  assign bus2.mode = mode;  assign bus2.out_ready = ready;  assign bus2.req = req[1:0];

    prio_enc_queue #(.N(8), .RR_EN(1)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    prio_enc_queue #(.N(5), .RR_EN(1)) dut5 (.clk(clk), .rst(rst), .bus(bus5));
    prio_enc_queue #(.N(2), .RR_EN(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Winner by search order: fixed = highest index; rotating = last-1 downward, modulo n.
    function automatic int search(input logic [63:0] pend, input int n, input int last, input bit rr);
        int c;
        if (rr) begin
            for (int d = 1; d <= n; d++) begin
                c = (last - d + n) % n;
                if (pend[c]) return c;
            end
        end else begin
            for (int c2 = n - 1; c2 >= 0; c2--) begin
                if (pend[c2]) return c2;
            end
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [63:0] mask, r, pm;
        int p;
        bit free;
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_pend[k] = 64'd0; m_valid[k] = 1'b0; m_idx[k] = 0; m_last[k] = 0; m_drop[k] = 1'b0;
                continue;
            end
            mask = (64'd1 << nn[k]) - 64'd1;
            r    = en ? (req & mask) : 64'd0;
            free = !m_valid[k] || ready;
            p    = (free && m_pend[k] != 64'd0) ? search(m_pend[k], nn[k], m_last[k], mode) : -1;
            pm   = (p >= 0) ? (64'd1 << p) : 64'd0;
            m_drop[k] = |(r & m_pend[k] & ~pm);
            if (free) begin
                m_valid[k] = (p >= 0);
                if (p >= 0) m_idx[k] = p;
            end
            if (p >= 0 && mode) m_last[k] = p;
            m_pend[k] = (m_pend[k] & ~pm) | r;
        end
    endtask

    task automatic compare_all();
        check_eq("m8_valid", 64'(bus8.out_valid), 64'(m_valid[0]));
        check_eq("m8_idx",   64'(bus8.out_idx),   64'(m_idx[0]));
        check_eq("m8_pend",  64'(bus8.pending),   m_pend[0]);
        check_eq("m8_drop",  64'(bus8.drop),      64'(m_drop[0]));
        check_eq("m5_valid", 64'(bus5.out_valid), 64'(m_valid[1]));
        check_eq("m5_idx",   64'(bus5.out_idx),   64'(m_idx[1]));
        check_eq("m5_pend",  64'(bus5.pending),   m_pend[1]);
        check_eq("m5_drop",  64'(bus5.drop),      64'(m_drop[1]));
        check_eq("m2_valid", 64'(bus2.out_valid), 64'(m_valid[2]));
        check_eq("m2_idx",   64'(bus2.out_idx),   64'(m_idx[2]));
        check_eq("m2_pend",  64'(bus2.pending),   m_pend[2]);
        check_eq("m2_drop",  64'(bus2.drop),      64'(m_drop[2]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int exp_idx[4];
        int exp_pend[4];
        for (int k = 0; k < NI; k++) begin
            m_pend[k] = 64'd0; m_valid[k] = 1'b0; m_idx[k] = 0; m_last[k] = 0; m_drop[k] = 1'b0;
        end
        rst = 1'b1; en = 1'b0; mode = MODE_FIXED; ready = 1'b0; req = 64'd0;

        // Reset state
        tick(); tick();
        check_eq("rst_valid", 64'(bus8.out_valid), 64'd0);
        check_eq("rst_idx",   64'(bus8.out_idx),   64'd0);
        check_eq("rst_pend",  64'(bus8.pending),   64'd0);
        check_eq("rst_drop",  64'(bus8.drop),      64'd0);

        // Single-hot requests, two-edge latency, then idle
        rst = 1'b0; en = 1'b1; ready = 1'b1;
        for (int b = 7; b >= 0; b--) begin
            req = 64'd1 << b;
            tick();
            req = 64'd0;
            tick();
            check_eq("single_valid", 64'(bus8.out_valid), 64'd1);
            check_eq("single_idx",   64'(bus8.out_idx),   64'(b));
            tick();
            check_eq("single_idle",  64'(bus8.out_valid), 64'd0);
        end

        // Fixed multi-hot drain: 7,5,2,1
        exp_idx  = '{7, 5, 2, 1};
        exp_pend = '{32'h26, 32'h06, 32'h02, 32'h00};
        req = 64'hA6;
        tick();
        req = 64'd0;
        check_eq("multi_pend0", 64'(bus8.pending), 64'hA6);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("multi_idx",  64'(bus8.out_idx), 64'(exp_idx[i]));
            check_eq("multi_pend", 64'(bus8.pending), 64'(exp_pend[i]));
        end
        tick();
        check_eq("multi_idle", 64'(bus8.out_valid), 64'd0);

        // Round-robin fairness 7,0,7,0..., then fixed 7,7,7
        mode = MODE_RR; req = 64'h81;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("rr_valid", 64'(bus8.out_valid), 64'd1);
            check_eq("rr_idx",   64'(bus8.out_idx),   (i % 2 == 0) ? 64'd7 : 64'd0);
        end
        mode = MODE_FIXED;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("fix_idx", 64'(bus8.out_idx), 64'd7);
        end
        req = 64'd0;
        tick(); tick(); tick();
        check_eq("rr_drained", 64'(bus8.pending), 64'd0);

        // Backpressure and merge
        ready = 1'b0; req = 64'h10;
        tick();
        check_eq("bp_pend", 64'(bus8.pending), 64'h10);
        req = 64'd0;
        tick();
        check_eq("bp_valid", 64'(bus8.out_valid), 64'd1);
        check_eq("bp_idx",   64'(bus8.out_idx),   64'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_hold_v", 64'(bus8.out_valid), 64'd1);
            check_eq("bp_hold_i", 64'(bus8.out_idx),   64'd4);
        end
        req = 64'h10;
        tick();
        check_eq("bp_recap", 64'(bus8.pending), 64'h10);
        check_eq("bp_nodrop", 64'(bus8.drop), 64'd0);
        tick();
        check_eq("bp_drop", 64'(bus8.drop), 64'd1);
        req = 64'd0;
        tick();
        check_eq("bp_drop_end", 64'(bus8.drop), 64'd0);
        ready = 1'b1;
        tick();
        check_eq("bp_issue_v", 64'(bus8.out_valid), 64'd1);
        check_eq("bp_issue_p", 64'(bus8.pending),   64'd0);
        tick();
        check_eq("bp_once", 64'(bus8.out_valid), 64'd0);

        // Enable low ignores requests; reset mid-drain clears the rotation pointer
        en = 1'b0; req = 64'hFF;
        tick(); tick(); tick();
        check_eq("en0_pend",  64'(bus8.pending),   64'd0);
        check_eq("en0_valid", 64'(bus8.out_valid), 64'd0);
        en = 1'b1;
        tick();
        check_eq("en1_pend", 64'(bus8.pending), 64'hFF);
        req = 64'd0; mode = MODE_RR;
        tick();
        check_eq("pre_rst_idx", 64'(bus8.out_idx), 64'd7);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_pend",  64'(bus8.pending),   64'd0);
        check_eq("mid_rst_valid", 64'(bus8.out_valid), 64'd0);
        rst = 1'b0; req = 64'hFF;
        tick();
        req = 64'd0;
        tick();
        check_eq("post_rst_rr", 64'(bus8.out_idx), 64'd7);

        // Non-power-of-two N=5 rotating 4,0,4,0
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = MODE_RR; req = 64'h11;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("n5_idx", 64'(bus5.out_idx), (i % 2 == 0) ? 64'd4 : 64'd0);
        end
        req = 64'd0;
        tick(); tick(); tick();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            en    = ($urandom_range(0, 3) != 0);
            mode  = 1'($urandom_range(0, 1));
            ready = ($urandom_range(0, 3) != 0);
            req   = {$urandom, $urandom} & {$urandom, $urandom};
            if (!en && $urandom_range(0, 1) == 1) req = 'x;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prio_enc_queue.md
Name: prio_enc_queue

Overview:
- Parametrised, registered N-to-log2(N) priority encoder with request capture and a valid/ready output.
- Latches incoming one-hot or multi-hot request vectors into a pending set.
- Issues one encoded index per accepted transfer, MSB-first (fixed mode) or rotating (round-robin mode).
- Sits between interrupt/event sources and a single consumer (interrupt controller, DMA channel select) that cannot take every request in the cycle it arrives.

Parameters:
- N, 8, number of request lines (2..64).
- W, $clog2(N), index width; derived, must not be overridden.
- RR_EN, 1, 1 builds round-robin support; 0 ties the mode input off to fixed priority.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  capture enable; when 0, req is ignored and pending still drains.
- req  input  N  request vector; bit k set means source k is requesting this cycle.
- mode  input  1  0 = fixed (highest index wins), 1 = round-robin (ignored when RR_EN=0).
- out_ready  input  1  consumer accepts out_idx this cycle.
- out_valid  output  1  out_idx holds an issued request.
- out_idx  output  W  encoded index of the issued request.
- pending  output  N  registered set of captured, not-yet-issued requests.
- drop  output  1  one-cycle pulse: a request hit a bit already pending and was merged.

Behaviour:
- Reset (rst=1 at clk edge): pending=0, out_valid=0, out_idx=0, drop=0, rr pointer last=0. This takes priority over all other updates, including mid-transfer.
- Slot free: free = !out_valid | out_ready.
- Pick: when free and pending!=0, select one bit p of pending (see search order).
  - Same edge: out_idx<=p, out_valid<=1, bit p cleared from pending, last<=p (only if mode=1).
- Idle: when free and pending==0, out_valid<=0 and out_idx holds its value.
- Stall: when out_valid=1 and out_ready=0, out_idx/out_valid hold and no pick occurs.
- Capture: pending_next = (pending & ~pick_mask) | (en ? req : 0).
  - A req bit equal to the bit being picked this cycle is re-captured (pending bit stays 1).
- Drop: drop <= en & |(req & pending & ~pick_mask). Registered, so it pulses the cycle after the merge.
- Latency: req at edge t gives pending at t+1 and out_valid at t+2 (empty queue, ready high). Throughput is 1 index per cycle while pending is non-empty and out_ready=1.
- Fixed search: highest set index of pending (req=8'b1000_0000 gives 7; matches the existing 8-to-3 encoder ordering).
- Round-robin search: indices last-1, last-2, ..., 0, N-1, ..., last, modulo N.
  - Reset value last=0 makes the first RR search identical to fixed order.
  - last updates only on picks made in mode=1.
  - Mode changes take effect at the next pick.
- Non-power-of-two N: bits ≥N do not exist; the wrap is modulo N, not 2^W.
- Enable low: no capture and drop=0; issued output and pending drain continue normally.
- No X propagation: req bits of X when en=0 must not affect state.

Decomposition:
- Package prio_enc_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1, and a function clog2_min1 (W≥1 for N=2).
- Sub-module prio_pick (combinational):
  - Inputs: vec[N], start[W], rr.
  - Outputs: any, idx[W], onehot[N].
  - Implementation: rotate vec right by start, find highest, un-rotate.
- The top level holds the pending register, output register, rr pointer and drop logic (~150–250 lines total).

Test Plan:
- Reset/basic: rst 2 cycles, then en=1, mode=0, out_ready=1, single-cycle req=8'h80 → out_valid=1, out_idx=3'd7 two edges later, then out_valid=0; repeat for 8'h40..8'h01 → 6..0.
- Fixed multi-hot: req=8'b1010_0110 one cycle, ready=1 → out_idx 7,5,2,1 on consecutive cycles, pending 8'hA6→8'h26→8'h06→8'h02→0.
- Round-robin fairness: mode=1, hold req=8'b1000_0001 every cycle → issued sequence 7,0,7,0,...; with mode=0 → 7,7,7,...
- Backpressure + drop: req=8'h10, out_ready=0 for 5 cycles → out_idx=4 held with out_valid=1; re-assert req=8'h10 twice while pending → drop pulses once per merge; on ready, only one index 4 issued afterward.
- Enable/reset mid-operation: en=0, req=8'hFF → pending stays 0, no output; en=1, req=8'hFF, then rst during drain → next edge pending=0, out_valid=0, last=0, and the first RR pick after reset is 7.
- Parameter sweep: N=5, mode=1, req=5'b10001 held → 4,0,4,0; N=2 builds with W=1.
